uart_tx: RTL and testbench

UART transmit serializer fed by the baud tick generator. Accepts one byte at a time over a valid/ready handshake and shifts it out on `tx` as an asynchronous frame: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits. Every bit lasts exactly one baud period, measured tick to tick, using the single-cycle `baud_tick` pulse. Sits between the host-side producer (core or FIFO) and the pad.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_if.sv | 13 +
 rtl/uart_tx.sv | 112 +++++++++++
 tb/tb_uart_tx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity modes.
// Imported by the transmitter today and by the receiver later.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Parity bit from the XOR-reduction of the data word.
    function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake plus serial line and status of the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 busy;

    modport master (output tx_data, output tx_valid, input tx_ready, input tx, input busy);
    modport slave  (input tx_data, input tx_valid, output tx_ready, output tx, output busy);
endinterface

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bits,
// each bit exactly one baud_tick interval long.
module uart_tx
    import uart_pkg::*;
#(
    parameter int         DATA_BITS = 8,
    parameter int         STOP_BITS = 1,
    parameter logic [1:0] PARITY    = PAR_NONE
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     baud_tick,
    uart_tx_if.slave bus
);

    localparam int                CNT_W      = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_BITS - 1);
    localparam logic              LAST_STOP  = 1'(STOP_BITS - 1);
    localparam bit                HAS_PARITY = (PARITY != PAR_NONE);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t       r_state;
    logic [DATA_BITS-1:0] r_shreg;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic                 r_tx;

    logic w_accept;
    logic w_shift;

    assign w_accept = (r_state == ST_IDLE) && bus.tx_valid;
    assign w_shift  = baud_tick &&
                      ((r_state == ST_START) ||
                       ((r_state == ST_DATA) && (r_bit_cnt != LAST_BIT)));

    // NOTE: the shift register and parity are pure datapath, always loaded on
    // acceptance before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shreg  <= bus.tx_data;
            r_parity <= parity_bit(PARITY, ^bus.tx_data);
        end else if (w_shift) begin
            r_shreg  <= r_shreg >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (bus.tx_valid) r_state <= ST_SYNC;
                end
                ST_SYNC: if (baud_tick) begin
                    r_tx    <= 1'b0;
                    r_state <= ST_START;
                end
                ST_START: if (baud_tick) begin
                    r_tx      <= r_shreg[0];
                    r_bit_cnt <= '0;
                    r_state   <= ST_DATA;
                end
                ST_DATA: if (baud_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        r_stop_cnt <= 1'b0;
                        if (HAS_PARITY) begin
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end
                    end else begin
                        // r_shreg[0] already holds the next bit after the previous shift
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_tx      <= r_shreg[0];
                    end
                end
                ST_PARITY: if (baud_tick) begin
                    r_tx       <= 1'b1;
                    r_stop_cnt <= 1'b0;
                    r_state    <= ST_STOP;
                end
                ST_STOP: if (baud_tick) begin
                    if (r_stop_cnt == LAST_STOP) r_state <= ST_IDLE;
                    else                         r_stop_cnt <= r_stop_cnt + 1'b1;
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx       = r_tx;
    assign bus.tx_ready = (r_state == ST_IDLE);
    assign bus.busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations (8N1, 8E1, 8O1, 8N2) against a
// frame-queue reference model, plus directed literal frames.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [3:0] valid;
    logic [7:0] data [4];

    wire  [3:0] w_ready;
    wire  [3:0] w_tx;
    wire  [3:0] w_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(8)) if_n ();
    uart_tx_if #(.DATA_BITS(8)) if_e ();
    uart_tx_if #(.DATA_BITS(8)) if_o ();
    uart_tx_if #(.DATA_BITS(8)) if_2 ();

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PAR_NONE)) dut_n (.clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if_n));
    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PAR_EVEN)) dut_e (.clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if_e));
    uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PAR_ODD))  dut_o (.clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if_o));
    uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .PARITY(PAR_NONE)) dut_2 (.clk(clk), .rst(rst), .baud_tick(baud_tick), .bus(if_2));

    assign if_n.tx_data = data[0];  assign if_n.tx_valid = valid[0];
    assign if_e.tx_data = data[1];  assign if_e.tx_valid = valid[1];
    assign if_o.tx_data = data[2];  assign if_o.tx_valid = valid[2];
    assign if_2.tx_data = data[3];  assign if_2.tx_valid = valid[3];

    assign w_ready = {if_2.tx_ready, if_o.tx_ready, if_e.tx_ready, if_n.tx_ready};
    assign w_tx    = {if_2.tx,       if_o.tx,       if_e.tx,       if_n.tx};
    assign w_busy  = {if_2.busy,     if_o.busy,     if_e.busy,     if_n.busy};

    localparam logic [1:0] CFG_PAR  [4] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE};
    localparam int         CFG_STOP [4] = '{1, 1, 1, 2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Baud tick: one-cycle pulse every 4 clocks
    initial begin
        int ph = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            ph        = (ph + 1) % 4;
            baud_tick = (ph == 0);
        end
    end

    // Reference model: each accepted word becomes a list of line levels; every tick
    // after acceptance puts the next level on the line, and the tick after the last
    // level returns to idle.
    logic [15:0] m_frame [4];
    int          m_len   [4];
    int          m_pos   [4];
    bit          m_idle  [4];
    logic        m_line  [4];
    bit          m_init = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_idle[i] = 1'b1;
                m_line[i] = 1'b1;
                m_len[i]  = 0;
                m_pos[i]  = 0;
            end else if (m_idle[i]) begin
                if (valid[i]) begin
                    int n;
                    m_frame[i]    = '0;
                    m_frame[i][0] = 1'b0;
                    for (int b = 0; b < 8; b++) m_frame[i][1+b] = data[i][b];
                    n = 9;
                    if (CFG_PAR[i] != PAR_NONE) begin
                        m_frame[i][n] = (^data[i]) ^ (CFG_PAR[i] == PAR_ODD);
                        n++;
                    end
                    for (int s = 0; s < CFG_STOP[i]; s++) begin
                        m_frame[i][n] = 1'b1;
                        n++;
                    end
                    m_len[i]  = n;
                    m_pos[i]  = 0;
                    m_idle[i] = 1'b0;
                end
            end else if (baud_tick) begin
                if (m_pos[i] < m_len[i]) begin
                    m_line[i] = m_frame[i][m_pos[i]];
                    m_pos[i]++;
                end else begin
                    m_idle[i] = 1'b1;
                    m_line[i] = 1'b1;
                end
            end
        end
        if (rst) m_init = 1'b1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model_tx[%0d]", i),    32'(w_tx[i]),    32'(m_line[i]));
                check($sformatf("model_ready[%0d]", i), 32'(w_ready[i]), 32'(m_idle[i]));
                check($sformatf("model_busy[%0d]", i),  32'(w_busy[i]),  32'(!m_idle[i]));
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d);
        int w = 0;
        data[i]  = d;
        valid[i] = 1'b1;
        do begin
            @(negedge clk);
            w++;
        end while (w_ready[i] && w < 50);
        if (w >= 50) check("send_timeout", 32'd0, 32'd1);
        valid[i] = 1'b0;
    endtask

    task automatic wait_fall(input int i, output int waited);
        waited = 0;
        while (w_tx[i] !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("fall_timeout", 32'd0, 32'd1);
    endtask

    // Called on the first cycle of the start bit; samples mid-bit until ready returns.
    task automatic capture(input int i, input int nbits, output logic [15:0] bits,
                           output int len, output logic busy_prev);
        int cnt = 0;
        bits      = '0;
        busy_prev = 1'b0;
        while (cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (w_ready[i]) break;
            busy_prev = w_busy[i];
            if (cnt % 4 == 2 && cnt / 4 < nbits) bits[cnt/4] = w_tx[i];
        end
        if (cnt >= 200) check("capture_timeout", 32'd0, 32'd1);
        len = cnt;
    endtask

    logic [15:0] bits;
    int          len;
    int          w;
    int          hold;
    logic        bprev;

    initial begin
        rst   = 1'b1;
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_tx",    32'(w_tx[i]),    32'd1);
            check("reset_ready", 32'(w_ready[i]), 32'd1);
            check("reset_busy",  32'(w_busy[i]),  32'd0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1, 0x55
        send(0, 8'h55);
        wait_fall(0, w);
        capture(0, 10, bits, len, bprev);
        check("t55_bits", 32'(bits[9:0]), 32'h2AA);
        check("t55_len",  32'(len),       32'd40);
        repeat (7) @(negedge clk);

        // valid held: 0xA5 then 0x3C back to back
        data[0]  = 8'hA5;
        valid[0] = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (w_ready[0] && w < 50);
        data[0] = 8'h3C;
        wait_fall(0, w);
        capture(0, 10, bits, len, bprev);
        check("tA5_bits", 32'(bits[9:0]), 32'h34A);
        check("tA5_len",  32'(len),       32'd40);
        @(negedge clk);
        check("b2b_ready_one_cycle", 32'(w_ready[0]), 32'd0);
        valid[0] = 1'b0;
        wait_fall(0, w);
        check("b2b_interframe_le8", 32'((5 + w) <= 8), 32'd1);
        capture(0, 10, bits, len, bprev);
        check("t3C_bits", 32'(bits[9:0]), 32'h278);
        check("t3C_len",  32'(len),       32'd40);
        repeat (6) @(negedge clk);

        // Parity even / odd on 0x07
        send(1, 8'h07);
        wait_fall(1, w);
        capture(1, 11, bits, len, bprev);
        check("even_bits",   32'(bits[10:0]), 32'h60E);
        check("even_parity", 32'(bits[9]),    32'd1);
        check("even_len",    32'(len),        32'd44);
        send(2, 8'h07);
        wait_fall(2, w);
        capture(2, 11, bits, len, bprev);
        check("odd_bits",   32'(bits[10:0]), 32'h40E);
        check("odd_parity", 32'(bits[9]),    32'd0);
        check("odd_len",    32'(len),        32'd44);

        // Two stop bits on 0xFF
        send(3, 8'hFF);
        wait_fall(3, w);
        capture(3, 11, bits, len, bprev);
        check("stop2_bits",      32'(bits[10:0]), 32'h7FE);
        check("stop2_len",       32'(len),        32'd44);
        check("stop2_busy_end",  32'(w_busy[3]),  32'd0);
        check("stop2_busy_prev", 32'(bprev),      32'd1);

        // Reset during data bit 3 of 0x00
        send(0, 8'h00);
        wait_fall(0, w);
        repeat (18) @(negedge clk);
        check("rst_mid_tx_low", 32'(w_tx[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx",    32'(w_tx[0]),    32'd1);
        check("rst_mid_ready", 32'(w_ready[0]), 32'd1);
        check("rst_mid_busy",  32'(w_busy[0]),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        send(0, 8'h81);
        wait_fall(0, w);
        capture(0, 10, bits, len, bprev);
        check("after_rst_bits", 32'(bits[9:0]), 32'h302);
        check("after_rst_len",  32'(len),       32'd40);

        // New data offered while busy is ignored
        send(0, 8'h0F);
        wait_fall(0, w);
        fork
            capture(0, 10, bits, len, bprev);
            begin
                repeat (10) @(negedge clk);
                data[0]  = 8'h99;
                valid[0] = 1'b1;
                repeat (8) @(negedge clk);
                valid[0] = 1'b0;
            end
        join
        check("busy_ignore_bits", 32'(bits[9:0]), 32'h21E);
        check("busy_ignore_len",  32'(len),       32'd40);
        hold = 0;
        repeat (12) begin
            @(negedge clk);
            if (w_ready[0] && w_tx[0]) hold++;
        end
        check("busy_ignore_stays_idle", 32'(hold), 32'd12);
        send(0, 8'h99);
        wait_fall(0, w);
        capture(0, 10, bits, len, bprev);
        check("t99_bits", 32'(bits[9:0]), 32'h332);

        // Randomized traffic on all configurations, with occasional reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                valid[i] = ($urandom_range(0, 3) == 0);
                data[i]  = 8'($urandom);
            end
            rst = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        rst   = 1'b0;
        valid = '0;
        repeat (120) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
